ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline interlock and sequencing controller for the execute stage.
- Detects load-use hazards that forwarding cannot cover.
- Sequences a multi-cycle EX unit (mul/div) through a start/done handshake.
- Applies branch-redirect flushes and memory-busy freezes.
- Drives per-stage stall/flush controls for pc, if2id, id2ex, ex2mem and mem2wb registers, and keeps a saturating stall-cycle counter.

Parameters:
REG_IDX_W, 5, register index width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, single domain
rst  in  1  asynchronous, active-high reset
id_rs1_en_i  in  1  ID instruction reads rs1
id_rs2_en_i  in  1  ID instruction reads rs2
id_rs1_index_i  in  REG_IDX_W  ID rs1 index
id_rs2_index_i  in  REG_IDX_W  ID rs2 index
id2ex_rd_en_i  in  1  EX instruction writes rd
id2ex_rd_index_i  in  REG_IDX_W  EX rd index
id2ex_mem_read_i  in  1  EX instruction is a load
id2ex_multi_cycle_i  in  1  EX instruction needs multi-cycle unit
ex_redirect_i  in  1  EX resolved taken branch/jump
mem_busy_i  in  1  MEM stage waiting on data bus
mcu_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
mcu_start_o  out  1  start pulse to multi-cycle unit
pc_stall_o  out  1  hold PC
if2id_stall_o  out  1  hold IF/ID register
if2id_flush_o  out  1  bubble into IF/ID
id2ex_stall_o  out  1  hold ID/EX register
id2ex_flush_o  out  1  bubble into ID/EX
ex2mem_stall_o  out  1  hold EX/MEM register
ex2mem_flush_o  out  1  bubble into EX/MEM
mem2wb_flush_o  out  1  bubble into MEM/WB
stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1, saturating

Behaviour:
- Reset: clock and reset are as Already decided above. rst=1 forces state=RUN and stall_cnt_o=0. While rst=1, all outputs are 0. Reset mid-multi-cycle-op abandons the op; no done is awaited afterwards.
- FSM states: RUN, MC_BUSY, MC_HOLD.
- Stage controls are combinational from state and inputs, evaluated in priority order. Each rule below lists only the outputs it drives to 1; all other outputs are 0.
  - P1, mem_busy_i=1: pc, if2id, id2ex and ex2mem stall; mem2wb_flush. Redirect and load-use actions are deferred; EX keeps its instruction, so they re-evaluate when busy drops.
  - P2, state MC_BUSY and mcu_done_i=0: pc, if2id and id2ex stall; ex2mem_flush.
  - P3, state RUN and id2ex_multi_cycle_i=1: mcu_start_o pulse; same controls as P2.
  - P4, state RUN and ex_redirect_i=1: if2id_flush and id2ex_flush. Takes precedence over load-use.
  - P5, state RUN and load-use: pc and if2id stall; id2ex_flush.
    - load-use = id2ex_mem_read_i & id2ex_rd_en_i & rd!=0 & ((id_rs1_en_i & rs1==rd) | (id_rs2_en_i & rs2==rd)).
    - Lasts exactly 1 cycle; forwarding covers the next cycle.
  - MC_BUSY with done=1, or MC_HOLD, with mem_busy_i=0: release cycle; no stalls, ex2mem captures the result.
- mcu_start_o is asserted in RUN whenever P3 matches, including when mem_busy_i=1 (P1 stage controls still apply). It is never asserted in MC_BUSY or MC_HOLD.
- Transitions:
  - RUN -> MC_BUSY on mcu_start_o.
  - MC_BUSY -> RUN on mcu_done_i & !mem_busy_i.
  - MC_BUSY -> MC_HOLD on mcu_done_i & mem_busy_i. The multi-cycle unit holds its result stable while in MC_HOLD.
  - MC_HOLD -> RUN when mem_busy_i=0.
  - mcu_done_i in RUN or MC_HOLD is ignored.
  - mcu_done_i is not sampled in the start cycle; minimum op latency is 1 cycle after start.
- Back-to-back multi-cycle instructions: after the release cycle the next EX instruction starts in the following RUN cycle.
- stall_cnt_o increments by 1 on each cycle with pc_stall_o=1. It saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Shared defines file: state encoding (HZ_RUN=2'd0, HZ_MC_BUSY=2'd1, HZ_MC_HOLD=2'd2), REG_INDEX_BUS width.
- One natural sub-module: hazard_stall_cnt (saturating counter, enable=pc_stall_o).
- FSM and priority logic stay in ex_hazard_ctrl.

Test Plan:
- Load-use: EX load rd=5, ID rs2_en=1 rs2=5 -> 1 cycle of pc/if2id stall and id2ex_flush; stall_cnt_o 0->1. Same stimulus with rd=0 -> no stall.
- Multi-cycle: id2ex_multi_cycle_i=1, done 4 cycles after start -> mcu_start_o high exactly 1 cycle; stalls for 4 cycles; release on the done cycle; stall_cnt_o=4.
- Done during busy: mem_busy_i=1 on the done cycle for 3 cycles -> MC_HOLD; P1 outputs for 3 cycles; release on the 4th cycle.
- Redirect with load-use: both conditions true in RUN -> if2id_flush=id2ex_flush=1, pc_stall_o=0.
- Redirect under mem_busy: redirect=1 for 2 busy cycles then busy=0 -> flushes only in the cycle busy drops.
- Reset mid-op: rst in MC_BUSY -> all outputs 0 asynchronously; after release, a late mcu_done_i pulse in RUN is ignored.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg: shared state encoding, widths and the load-use hazard rule
package ex_hazard_ctrl_pkg;
  localparam int REG_INDEX_BUS = 5;
  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MC_BUSY = 2'd1,
    HZ_MC_HOLD = 2'd2
  } hz_state_e;
  // A load in EX whose rd feeds an ID source cannot be forwarded in time; x0 never hazards
  function automatic logic load_use(
    input logic                     mem_read,
    input logic                     rd_en,
    input logic [REG_INDEX_BUS-1:0] rd,
    input logic                     rs1_en,
    input logic [REG_INDEX_BUS-1:0] rs1,
    input logic                     rs2_en,
    input logic [REG_INDEX_BUS-1:0] rs2
  );
    return mem_read & rd_en & (rd != '0) & ((rs1_en & (rs1 == rd)) | (rs2_en & (rs2 == rd)));
  endfunction
endpackage

// File: rtl/ex_hazard_ctrl_stall_cnt.sv
// hazard_stall_cnt: saturating count of stalled cycles
module hazard_stall_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_en && (r_cnt != '1)) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage interlock, multi-cycle sequencing and pipeline stall/flush control
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = REG_INDEX_BUS,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_rs1_en_i,
  input  logic                 id_rs2_en_i,
  input  logic [REG_IDX_W-1:0] id_rs1_index_i,
  input  logic [REG_IDX_W-1:0] id_rs2_index_i,
  input  logic                 id2ex_rd_en_i,
  input  logic [REG_IDX_W-1:0] id2ex_rd_index_i,
  input  logic                 id2ex_mem_read_i,
  input  logic                 id2ex_multi_cycle_i,
  input  logic                 ex_redirect_i,
  input  logic                 mem_busy_i,
  input  logic                 mcu_done_i,
  output logic                 mcu_start_o,
  output logic                 pc_stall_o,
  output logic                 if2id_stall_o,
  output logic                 if2id_flush_o,
  output logic                 id2ex_stall_o,
  output logic                 id2ex_flush_o,
  output logic                 ex2mem_stall_o,
  output logic                 ex2mem_flush_o,
  output logic                 mem2wb_flush_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);
  hz_state_e r_state, w_next;
  logic w_run, w_lu, w_p1, w_p2, w_p3, w_p4, w_p5;
  // Hold the sequencing state; reset abandons any in-flight multi-cycle op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HZ_RUN;
    else r_state <= w_next;
  end
  // Priority-resolved stage controls and next state; everything is forced low during reset
  always_comb begin
    w_run = r_state == HZ_RUN;
    w_lu  = load_use(id2ex_mem_read_i, id2ex_rd_en_i, id2ex_rd_index_i,
                     id_rs1_en_i, id_rs1_index_i, id_rs2_en_i, id_rs2_index_i);
    w_p1  = mem_busy_i;
    w_p3  = w_run & id2ex_multi_cycle_i;
    w_p2  = !w_p1 & (((r_state == HZ_MC_BUSY) & !mcu_done_i) | w_p3);
    w_p4  = !w_p1 & !w_p2 & w_run & ex_redirect_i;
    w_p5  = !w_p1 & !w_p2 & !w_p4 & w_run & w_lu;
    w_next = w_run ? (w_p3 ? HZ_MC_BUSY : HZ_RUN) :
             (r_state == HZ_MC_BUSY) ? (mcu_done_i ? (mem_busy_i ? HZ_MC_HOLD : HZ_RUN) : HZ_MC_BUSY) :
             (mem_busy_i ? HZ_MC_HOLD : HZ_RUN);
    mcu_start_o    = !rst & w_p3;
    pc_stall_o     = !rst & (w_p1 | w_p2 | w_p5);
    if2id_stall_o  = !rst & (w_p1 | w_p2 | w_p5);
    if2id_flush_o  = !rst & w_p4;
    id2ex_stall_o  = !rst & (w_p1 | w_p2);
    id2ex_flush_o  = !rst & (w_p4 | w_p5);
    ex2mem_stall_o = !rst & w_p1;
    ex2mem_flush_o = !rst & w_p2;
    mem2wb_flush_o = !rst & w_p1;
  end
  hazard_stall_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (pc_stall_o),
    .o_cnt(stall_cnt_o)
  );
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed and random checks of ex_hazard_ctrl against a rule-level model
module tb_ex_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 6;
  localparam int unsigned MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rs1_en = 0, rs2_en = 0, rd_en = 0, ld = 0, multi = 0, redir = 0, mbusy = 0, done = 0;
  logic [RW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic start, pc_st, if_st, if_fl, ie_st, ie_fl, em_st, em_fl, mw_fl;
  logic [CW-1:0] cnt;
  int checks = 0;
  int errors = 0;
  int ph = 0;
  int unsigned m_cnt = 0;
  always #5 clk = ~clk;
  ex_hazard_ctrl #(.REG_IDX_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_en_i(rs1_en), .id_rs2_en_i(rs2_en),
    .id_rs1_index_i(rs1), .id_rs2_index_i(rs2),
    .id2ex_rd_en_i(rd_en), .id2ex_rd_index_i(rd),
    .id2ex_mem_read_i(ld), .id2ex_multi_cycle_i(multi),
    .ex_redirect_i(redir), .mem_busy_i(mbusy), .mcu_done_i(done),
    .mcu_start_o(start), .pc_stall_o(pc_st),
    .if2id_stall_o(if_st), .if2id_flush_o(if_fl),
    .id2ex_stall_o(ie_st), .id2ex_flush_o(ie_fl),
    .ex2mem_stall_o(em_st), .ex2mem_flush_o(em_fl),
    .mem2wb_flush_o(mw_fl), .stall_cnt_o(cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // ph: 0 = pipeline running, 1 = waiting on multi-cycle result, 2 = result parked behind busy MEM
  function automatic logic [8:0] model_ctl();
    logic [8:0] e;
    logic hit;
    hit = 1'b0;
    if (ld && rd_en && rd != 0) begin
      if (rs1_en && rs1 == rd) hit = 1'b1;
      if (rs2_en && rs2 == rd) hit = 1'b1;
    end
    e = '0;
    if (rst) return e;
    e[8] = (ph == 0) && multi;
    if (mbusy) e |= 9'b011010101;
    else if ((ph == 1 && !done) || e[8]) e |= 9'b011010010;
    else if (ph == 0 && redir) e |= 9'b000101000;
    else if (ph == 0 && hit) e |= 9'b011001000;
    return e;
  endfunction
  task automatic step(input string tag);
    logic [8:0] e;
    e = model_ctl();
    #1;
    chk({tag, " ctl"}, {55'd0, start, pc_st, if_st, if_fl, ie_st, ie_fl, em_st, em_fl, mw_fl}, {55'd0, e});
    chk({tag, " cnt"}, {58'd0, cnt}, rst ? 64'd0 : 64'(m_cnt));
    @(posedge clk);
    if (rst) begin
      ph = 0;
      m_cnt = 0;
    end else begin
      if (e[7] && m_cnt < MAXC) m_cnt++;
      if (ph == 0 && multi) ph = 1;
      else if (ph == 1 && done) ph = mbusy ? 2 : 0;
      else if (ph == 2 && !mbusy) ph = 0;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    {rs1_en, rs2_en, rd_en, ld, multi, redir, mbusy, done} = '0;
    {rs1, rs2, rd} = '0;
  endtask
  initial begin
    @(negedge clk);
    step("reset0");
    step("reset1");
    rst = 0;
    step("idle");
    ld = 1; rd_en = 1; rd = 5; rs2_en = 1; rs2 = 5;
    step("loaduse");
    rd = 0; rs2 = 0;
    step("loaduse_x0");
    idle();
    step("after_lu");
    #1 chk("lu_cnt", {58'd0, cnt}, 64'd1);
    multi = 1;
    step("mc_start");
    for (int i = 0; i < 3; i++) step("mc_wait");
    done = 1; multi = 0;
    step("mc_release");
    done = 0;
    #1 chk("mc_cnt", {58'd0, cnt}, 64'd5);
    multi = 1;
    step("hold_start");
    step("hold_wait");
    done = 1; mbusy = 1; multi = 0;
    step("hold_done_busy");
    done = 0;
    step("hold1");
    step("hold2");
    mbusy = 0;
    step("hold_release");
    #1 chk("hold_cnt", {58'd0, cnt}, 64'd10);
    redir = 1; ld = 1; rd_en = 1; rd = 7; rs1_en = 1; rs1 = 7;
    step("redir_lu");
    idle();
    redir = 1; mbusy = 1;
    step("redir_busy0");
    step("redir_busy1");
    mbusy = 0;
    step("redir_drop");
    idle();
    multi = 1;
    step("rst_start");
    step("rst_wait");
    #2 rst = 1;
    #1 chk("async_rst_pc", {63'd0, pc_st}, 64'd0);
    chk("async_rst_cnt", {58'd0, cnt}, 64'd0);
    @(negedge clk);
    step("rst_mid");
    rst = 0; multi = 0;
    step("rst_after");
    done = 1;
    step("late_done");
    done = 0;
    step("late_done_after");
    mbusy = 1;
    for (int i = 0; i < 70; i++) step("sat");
    #1 chk("sat_cnt", {58'd0, cnt}, 64'(MAXC));
    idle();
    for (int i = 0; i < 600; i++) begin
      rst    = $urandom_range(0, 199) == 0;
      rs1_en = $urandom_range(0, 1) == 1;
      rs2_en = $urandom_range(0, 1) == 1;
      rd_en  = $urandom_range(0, 1) == 1;
      ld     = $urandom_range(0, 1) == 1;
      rs1    = RW'($urandom_range(0, 3));
      rs2    = RW'($urandom_range(0, 3));
      rd     = RW'($urandom_range(0, 3));
      multi  = $urandom_range(0, 3) == 0;
      redir  = $urandom_range(0, 3) == 0;
      mbusy  = $urandom_range(0, 3) == 0;
      done   = $urandom_range(0, 3) == 0;
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
